// File: rtl/hann_window_if.sv
// hann_window_if: loader, sample, windowed-output and coefficient RAM signals of hann_window_ctrl
interface hann_window_if #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16
);
   logic                  coef_load_req;
   logic                  coef_wr_valid;
   logic                  coef_wr_ready;
   logic [DATA_WIDTH-1:0] coef_wr_data;
   logic                  smp_valid;
   logic                  smp_ready;
   logic [DATA_WIDTH-1:0] smp_data;
   logic                  win_valid;
   logic [DATA_WIDTH-1:0] win_data;
   logic                  win_last;
   logic                  coef_loaded;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wr_data;
   logic                  ram_wr_en;
   logic [DATA_WIDTH-1:0] ram_rd_data;
   modport slave (
      input  coef_load_req, coef_wr_valid, coef_wr_data, smp_valid, smp_data, ram_rd_data,
      output coef_wr_ready, smp_ready, win_valid, win_data, win_last, coef_loaded,
             ram_addr, ram_wr_data, ram_wr_en
   );
   modport master (
      output coef_load_req, coef_wr_valid, coef_wr_data, smp_valid, smp_data, ram_rd_data,
      input  coef_wr_ready, smp_ready, win_valid, win_data, win_last, coef_loaded,
             ram_addr, ram_wr_data, ram_wr_en
   );
endinterface

// File: rtl/hann_window_ctrl.sv
// hann_window_ctrl: shares the Hann coefficient RAM between the coefficient loader and the windowing path
module hann_window_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16
) (
   input logic          clk,
   input logic          tb_rst,
   hann_window_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   localparam int DW = DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST = '1;
   state_t                state;
   logic [ADDR_WIDTH-1:0] idx;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  load_pend;
   logic                  coef_hs;
   logic                  smp_hs;
   logic                  at_last;
   logic                  vld1;
   logic                  last1;
   logic signed [DW-1:0]  smp_q;
   logic [2*DW:0]         prod;
   assign coef_hs = bus.coef_wr_valid & bus.coef_wr_ready;
   assign smp_hs  = bus.smp_valid & bus.smp_ready;
   assign at_last = idx == LAST;
   assign bus.coef_wr_ready = state == LOAD;
   // A pending reload blocks new frames from IDLE but lets the running frame finish.
   assign bus.smp_ready = bus.coef_loaded & (state != LOAD) & ~bus.coef_load_req
                        & ((state == RUN) | ~load_pend);
   assign bus.ram_addr    = (coef_hs | smp_hs) ? idx : addr_q;
   assign bus.ram_wr_en   = coef_hs;
   assign bus.ram_wr_data = coef_hs ? bus.coef_wr_data : '0;
   // Coefficient is unsigned Q0.16, so it is zero-extended into the signed product.
   assign prod = (2*DW+1)'(smp_q) * (2*DW+1)'({1'b0, bus.ram_rd_data});
   // Sequencer: frame index, load bookkeeping and the held RAM address.
   always_ff @(posedge clk or posedge tb_rst)
      if (tb_rst) begin
         state           <= IDLE;
         idx             <= '0;
         addr_q          <= '0;
         load_pend       <= 1'b0;
         bus.coef_loaded <= 1'b0;
      end else begin
         if (coef_hs || smp_hs) begin
            idx    <= idx + ADDR_WIDTH'(1);
            addr_q <= idx;
         end
         case (state)
            IDLE:
               if (bus.coef_load_req || load_pend) begin
                  state           <= LOAD;
                  idx             <= '0;
                  bus.coef_loaded <= 1'b0;
               end else if (smp_hs) state <= RUN;
            LOAD:
               if (coef_hs && at_last) begin
                  state           <= IDLE;
                  bus.coef_loaded <= 1'b1;
                  load_pend       <= 1'b0;
               end
            RUN: begin
               if (bus.coef_load_req) load_pend <= 1'b1;
               if (smp_hs && at_last) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   // Two-stage window pipeline: hold the sample while the RAM reads, then register the scaled product.
   always_ff @(posedge clk or posedge tb_rst)
      if (tb_rst) begin
         smp_q         <= '0;
         vld1          <= 1'b0;
         last1         <= 1'b0;
         bus.win_valid <= 1'b0;
         bus.win_last  <= 1'b0;
         bus.win_data  <= '0;
      end else begin
         smp_q         <= smp_hs ? bus.smp_data : smp_q;
         vld1          <= smp_hs;
         last1         <= smp_hs & at_last;
         bus.win_valid <= vld1;
         bus.win_last  <= vld1 & last1;
         bus.win_data  <= vld1 ? DW'(prod >> DW) : '0;
      end
endmodule
